jk_register_bank: RTL and testbench
===================================

# jk_register_bank

Parametrised bank of WIDTH JK flip-flops sharing one clock and reset, with per-bit J/K inputs and a runtime mode select that reuses the bank as JK, D or T storage, or as a synchronous up/down counter. It is the multi-bit successor to the single JK flip-flop in the Flipflops library. It targets control registers, status latches and small event counters. Outputs are fully deterministic from reset, and y_bar is always the exact complement of y.

## Interface
- WIDTH, 8: number of flip-flops in the bank (≥1).
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into y on reset.
- clock  input  1  rising-edge clock for all state.
- reset  input  1  reset, asynchronous, active-high.
- en  input  1  synchronous enable; 0 holds all state.
- mode  input  2  00 JK, 01 D, 10 T, 11 COUNT.
- j  input  WIDTH  per-bit J / D / T input; unused in COUNT.
- k  input  WIDTH  per-bit K input in JK mode; k[0] is the count direction in COUNT (0 up, 1 down); otherwise ignored.
- y  output  WIDTH  bank state, registered.
- y_bar  output  WIDTH  ~y, registered alongside y.
- tc  output  1  terminal count, combinational from state and inputs.
- changed  output  1  registered one-cycle pulse: y changed at the previous edge.

## Operation
- Reset asserted: immediately y=RESET_VALUE, y_bar=~RESET_VALUE, changed=0, tc=0. This holds while reset is high and overrides clock and en.
- en=0: y, y_bar hold. changed goes to 0 at the next edge.
- Per bit i, when en=1:
  - JK (00): j=0,k=0 hold; j=0,k=1 clear; j=1,k=0 set; j=1,k=1 toggle.
  - D (01): y[i] <= j[i].
  - T (10): y[i] <= y[i] ^ j[i].
  - COUNT (11): the whole bank is an unsigned counter. y <= y+1 if k[0]=0, y-1 if k[0]=1, modulo 2^WIDTH. It wraps all-ones→0 (up) and 0→all-ones (down).
- y_bar is updated in the same edge as y. It is never X and never equal to y.
- Any X/Z on j or k in a selected bit does not corrupt other bits (per-bit evaluation).
- tc = en & (mode==COUNT) & ((k[0]==0 & y=={WIDTH{1}}) | (k[0]==1 & y==0)). tc=0 in all other modes.
- changed <= en & (next_y != y), evaluated at each edge.

## Timing
- Latency of y: 1 clock from input sampling.
- tc: 0-cycle combinational. It is high in the cycle before the wrap edge.
- changed: high exactly the cycle after the edge that modified y.
- A mode change takes effect at the next edge. There is no pipeline and no dead cycle.
- Reset deasserting at or near an edge: state resumes from RESET_VALUE at the first edge with reset low. Deassertion must meet recovery time relative to clock.
- Reset mid-count: the count is discarded. tc and changed drop immediately or at the next evaluation.

## Configuration
- JK_BANK_COUNT_MODE_EN defined: COUNT mode, the adder/subtractor and tc are compiled in, as above.
- Not defined: mode 11 behaves as hold (same as en=0). tc is tied to 0, and no counter logic is synthesised.

## Test plan
- Reset with RESET_VALUE=8'hA5, pulse reset between edges → y=A5, y_bar=5A, changed=0 asynchronously, before any clock edge.
- JK, y=00, j=F0,k=0F, edge → y=F0. Then j=FF,k=FF, edge → y=0F, changed=1 next cycle. Then j=00,k=00 → y=0F, changed=0.
- D and T: D with j=3C → y=3C. Then T with j=FF → y=C3. With en=0 and j=FF → y stays C3.
- COUNT up from FE: edge → FF with tc=1 during FF. Next edge → 00 with tc=0. k[0]=1 from 00 → tc=1, next edge → FF.
- Reset asserted mid-count at y=7F → y=RESET_VALUE immediately. The first edge after release counts from RESET_VALUE.
- Macro undefined: mode=11, en=1 for 4 edges → y unchanged, tc=0, changed=0.

Source files
------------

// File: rtl/jk_register_bank.sv
// jk_register_bank: WIDTH-bit bank of JK flip-flops, runtime reusable as JK/D/T storage or an up/down counter.
// Optional macro JK_BANK_COUNT_MODE_EN compiles in COUNT mode and tc; otherwise mode 11 holds and tc=0.
`timescale 1ns/1ps
`default_nettype none

module jk_register_bank #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_bar,
    output logic             tc,
    output logic             changed
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_D     = 2'b01;
    localparam logic [1:0] MODE_T     = 2'b10;
    localparam logic [1:0] MODE_COUNT = 2'b11;

    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_bar_q;
    logic             changed_q;
    logic             changed_d;

    // Bitwise forms keep an unknown j/k bit confined to its own flip-flop.
    always_comb begin
        y_d = y_q;
        if (en) begin
            case (mode)
                MODE_JK: y_d = (j & ~y_q) | (~k & y_q);
                MODE_D:  y_d = j;
                MODE_T:  y_d = y_q ^ j;
                MODE_COUNT: begin
`ifdef JK_BANK_COUNT_MODE_EN
                    if (k[0])
                        y_d = y_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    else
                        y_d = y_q + {{(WIDTH-1){1'b0}}, 1'b1};
`else
                    y_d = y_q;
`endif
                end
                default: y_d = y_q;
            endcase
        end
    end

    assign changed_d = en & (y_d != y_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            y_q       <= RESET_VALUE;
            y_bar_q   <= ~RESET_VALUE;
            changed_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_bar_q   <= ~y_d;
            changed_q <= changed_d;
        end
    end

`ifdef JK_BANK_COUNT_MODE_EN
    // Reset gating keeps tc low even when RESET_VALUE sits on a wrap point.
    assign tc = ~reset & en & (mode == MODE_COUNT) &
                ((~k[0] & (&y_q)) | (k[0] & ~(|y_q)));
`else
    assign tc = 1'b0;
`endif

    assign y       = y_q;
    assign y_bar   = y_bar_q;
    assign changed = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_register_bank.sv
// Scoreboard bench for jk_register_bank: directed plan plus randomized stimulus against an arithmetic model.
`timescale 1ns/1ps

module tb_jk_register_bank;

    localparam int          W   = 8;
    localparam int          MOD = 1 << W;
    localparam logic [W-1:0] RV = 8'hA5;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         en    = 1'b0;
    logic [1:0]   mode  = 2'b00;
    logic [W-1:0] j     = '0;
    logic [W-1:0] k     = '0;
    logic [W-1:0] y, y_bar;
    logic         tc, changed;

    jk_register_bank #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .y       (y),
        .y_bar   (y_bar),
        .tc      (tc),
        .changed (changed)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] y;
        logic [W-1:0] yb;
        logic         ch;
    } exp_t;

    exp_t out_q[$];
    bit   tc_q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_y;
    bit   m_ch;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: next value from the mode rules, counter as modular arithmetic.
    function automatic int model_next(int cur, bit e, int md, int jj, int kk);
        int r;
        if (!e) return cur;
        case (md)
            0: begin
                r = 0;
                for (int i = 0; i < W; i++) begin
                    int bj, bk, by, bn;
                    bj = (jj >> i) & 1;
                    bk = (kk >> i) & 1;
                    by = (cur >> i) & 1;
                    if (bj == 0 && bk == 0)      bn = by;
                    else if (bj == 0)            bn = 0;
                    else if (bk == 0)            bn = 1;
                    else                         bn = 1 - by;
                    r = r | (bn << i);
                end
                return r;
            end
            1: return jj % MOD;
            2: return (cur ^ jj) % MOD;
            default: begin
`ifdef JK_BANK_COUNT_MODE_EN
                if ((kk & 1) == 1) return (cur + MOD - 1) % MOD;
                return (cur + 1) % MOD;
`else
                return cur;
`endif
            end
        endcase
    endfunction

    task automatic step(input bit e, input int md, input int jj, input int kk);
        exp_t ex;
        bit   etc;
        int   nxt;
        logic [W-1:0] ny;
        @(negedge clock);
        en   = e;
        mode = md[1:0];
        j    = jj[W-1:0];
        k    = kk[W-1:0];
        etc = 1'b0;
`ifdef JK_BANK_COUNT_MODE_EN
        etc = e && md == 3 && ((((kk & 1) == 0) && m_y == MOD - 1) || (((kk & 1) == 1) && m_y == 0));
`endif
        tc_q.push_back(etc);
        nxt  = model_next(m_y, e, md, jj, kk);
        m_ch = e && (nxt != m_y);
        m_y  = nxt;
        ny   = m_y[W-1:0];
        ex.y  = ny;
        ex.yb = ~ny;
        ex.ch = m_ch;
        out_q.push_back(ex);
    endtask

    // Asynchronous reset asserted between edges, held across one edge, released at a falling edge.
    task automatic do_reset();
        @(posedge clock);
        #3;
        en    = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_y", y, RV);
        check("rst_ybar", y_bar, ~RV);
        check("rst_changed", {{(W-1){1'b0}}, changed}, '0);
        check("rst_tc", {{(W-1){1'b0}}, tc}, '0);
        m_y  = int'(RV);
        m_ch = 1'b0;
        @(posedge clock);
        #1;
        check("rst_hold_y", y, RV);
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin : monitor_out
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                check("y", y, e.y);
                check("y_bar", y_bar, e.yb);
                check("changed", {{(W-1){1'b0}}, changed}, {{(W-1){1'b0}}, e.ch});
            end
        end
    end

    initial begin : monitor_tc
        bit b;
        forever begin
            @(negedge clock);
            #3;
            if (tc_q.size() > 0) begin
                b = tc_q.pop_front();
                check("tc", {{(W-1){1'b0}}, tc}, {{(W-1){1'b0}}, b});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        m_y  = int'(RV);
        m_ch = 1'b0;
        do_reset();

        step(1, 1, 8'h00, 8'h00);
        step(1, 0, 8'hF0, 8'h0F);
        step(1, 0, 8'hFF, 8'hFF);
        step(1, 0, 8'h00, 8'h00);
        step(1, 1, 8'h3C, 8'h00);
        step(1, 2, 8'hFF, 8'h00);
        step(0, 2, 8'hFF, 8'h00);

`ifdef JK_BANK_COUNT_MODE_EN
        step(1, 1, 8'hFE, 8'h00);
        step(1, 3, 8'h00, 8'h00);
        step(1, 3, 8'h00, 8'h00);
        step(1, 3, 8'h00, 8'h01);
        step(1, 1, 8'h7E, 8'h00);
        step(1, 3, 8'h00, 8'h00);
        do_reset();
        step(1, 3, 8'h00, 8'h00);
`else
        for (int n = 0; n < 4; n++) step(1, 3, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
`endif

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3),
                 $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
        end

        @(posedge clock);
        @(negedge clock);
        #5;
        tests++;
        if (out_q.size() != 0 || tc_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", out_q.size(), tc_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
